// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {S_ADDR, S_LATCH, S_BLANK, S_SHOW} scan_state_e;

  // Width needed to hold values 0..value-1; never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot counter: runs 0..SCAN_DIV-1 and flags the last cycle of each slot.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [clog2(SCAN_DIV)-1:0] cycle,
  output logic                        slot_end
);

  localparam int unsigned CW = clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cycle_q, cycle_d;

  assign slot_end = (cycle_q == LAST);
  assign cycle    = cycle_q;

  always_comb begin
    cycle_d = slot_end ? '0 : cycle_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed common-anode display scanner with frame-aligned scrolling of a ROM message.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned CHAR_W        = 4,
  parameter int unsigned MSG_LEN       = 16,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned BLANK_CYC     = 500,
  parameter int unsigned SCROLL_FRAMES = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic                       auto_en,
  input  logic [CHAR_W-1:0]          msg_char,
  output logic [clog2(MSG_LEN)-1:0]  msg_addr,
  output logic [CHAR_W-1:0]          char_out,
  output logic [DIGITS-1:0]          an,
  output logic [clog2(DIGITS)-1:0]   digit_idx,
  output logic                       frame_start
);

  localparam int unsigned AW = clog2(MSG_LEN);
  localparam int unsigned DW = clog2(DIGITS);
  localparam int unsigned CW = clog2(SCAN_DIV);
  localparam int unsigned FW = clog2(SCROLL_FRAMES);
  localparam logic [DW-1:0] LAST_DIGIT  = DW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [FW-1:0] FRAMES_LAST = FW'(SCROLL_FRAMES - 1);

  scan_state_e       state_q, state_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [AW-1:0]     offset_q, offset_d;
  logic              pending_q, pending_d;
  logic [FW-1:0]     frames_q, frames_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [CW-1:0]     cycle;
  logic              slot_end, frame_end, auto_tick;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk      (clk),
    .reset    (reset),
    .cycle    (cycle),
    .slot_end (slot_end)
  );

  assign frame_end = slot_end && (digit_q == LAST_DIGIT);

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    offset_d  = offset_q;
    pending_d = pending_q;
    frames_d  = frames_q;
    addr_d    = addr_q;
    char_d    = char_q;
    auto_tick = 1'b0;

    unique case (state_q)
      S_ADDR:  state_d = S_LATCH;
      S_LATCH: begin
        char_d  = msg_char;
        state_d = (BLANK_CYC > 2) ? S_BLANK : S_SHOW;
      end
      S_BLANK: if (cycle == BLANK_LAST) state_d = S_SHOW;
      S_SHOW:  if (slot_end) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase

    if (!auto_en) begin
      frames_d = '0;
    end else if (frame_end) begin
      if (frames_q == FRAMES_LAST) begin
        frames_d  = '0;
        auto_tick = 1'b1;
      end else begin
        frames_d = frames_q + 1'b1;
      end
    end

    // A request arriving while one is already pending (or being applied) is dropped.
    if (frame_end && pending_q) begin
      offset_d  = offset_q + 1'b1;
      pending_d = 1'b0;
    end else if (step || auto_tick) begin
      pending_d = 1'b1;
    end

    // The address for the next slot is registered so it is valid in that slot's cycle 0.
    if (slot_end) begin
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
      addr_d  = offset_d + AW'(digit_d);
    end

    an_d = (state_d == S_SHOW) ? ~(DIGITS'(1) << digit_q) : '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_ADDR;
      digit_q   <= '0;
      offset_q  <= '0;
      pending_q <= 1'b0;
      frames_q  <= '0;
      addr_q    <= '0;
      char_q    <= '0;
      an_q      <= '1;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      offset_q  <= offset_d;
      pending_q <= pending_d;
      frames_q  <= frames_d;
      addr_q    <= addr_d;
      char_q    <= char_d;
      an_q      <= an_d;
    end
  end

  assign msg_addr  = addr_q;
  assign char_out  = char_q;
  assign an        = an_q;
  assign digit_idx = digit_q;
  // Combinational so the very first slot after reset release is flagged too.
  assign frame_start = (state_q == S_ADDR) && (digit_q == '0) && !reset;

endmodule
